// File: rtl/seg_disp_ctrl.sv
// Binary-to-BCD display controller: double-dabble conversion, overflow
// handling and leading-zero blanking for an 8-digit seven-segment driver.
module seg_disp_ctrl #(
  parameter bit P_OVF_SAT  = 1'b1,
  parameter bit P_BLANK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_bin,
  input  logic        i_bin_valid,
  output logic        o_bin_ready,
  input  logic [2:0]  i_dp_pos,
  input  logic        i_hold,
  output logic [31:0] o_data,
  output logic [2:0]  o_sw_state,
  output logic        o_ovf,
  output logic        o_busy,
  output logic        o_upd
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    BLANK,
    UPDATE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  dp_q, dp_d;
  logic [31:0] disp_q, disp_d;
  logic        ovfr_q, ovfr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  sw_q, sw_d;
  logic        ovf_q, ovf_d;
  logic        upd_q, upd_d;

  logic        accept;
  logic [39:0] bcd_adj;
  logic [31:0] disp_calc;
  logic        ovf_calc;
  logic        run_zero;

  assign o_bin_ready = (state_q == IDLE) && !i_hold;
  assign accept      = i_bin_valid && o_bin_ready;
  assign o_busy      = (state_q != IDLE);
  assign o_data      = data_q;
  assign o_sw_state  = sw_q;
  assign o_ovf       = ovf_q;
  assign o_upd       = upd_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // run_zero tracks "this digit and all above are zero", seeded by overflow
  always_comb begin
    ovf_calc  = |bcd_q[39:32];
    disp_calc = bcd_q[31:0];
    run_zero  = !ovf_calc;
    for (int k = 7; k >= 0; k--) begin
      run_zero = run_zero && (bcd_q[k*4 +: 4] == 4'd0);
      if (P_BLANK_EN && run_zero && (k != 0)
          && (k > int'(dp_q))) begin
        disp_calc[k*4 +: 4] = 4'hA;
      end
    end
    if (ovf_calc && P_OVF_SAT) begin
      disp_calc = 32'h9999_9999;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    disp_d  = disp_q;
    ovfr_d  = ovfr_q;
    data_d  = data_q;
    sw_d    = sw_q;
    ovf_d   = ovf_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bin_d   = i_bin;
          dp_d    = i_dp_pos;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        disp_d  = disp_calc;
        ovfr_d  = ovf_calc;
        state_d = UPDATE;
      end
      UPDATE: begin
        data_d  = disp_q;
        sw_d    = dp_q;
        ovf_d   = ovfr_q;
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dp_q    <= '0;
      disp_q  <= '0;
      ovfr_q  <= 1'b0;
      data_q  <= 32'hAAAA_AAAA;
      sw_q    <= '0;
      ovf_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      disp_q  <= disp_d;
      ovfr_q  <= ovfr_d;
      data_q  <= data_d;
      sw_q    <= sw_d;
      ovf_q   <= ovf_d;
      upd_q   <= upd_d;
    end
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Randomized bench for seg_disp_ctrl against a decimal-arithmetic model;
// three instances cover saturation, wrap and no-blanking variants.
module tb_seg_disp_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] i_bin = '0;
  logic        i_bin_valid = 1'b0;
  logic [2:0]  i_dp_pos = '0;
  logic        i_hold = 1'b0;

  logic [31:0] data_a, data_b, data_c;
  logic [2:0]  sw_a, sw_b, sw_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        busy_a, busy_b, busy_c;
  logic        upd_a, upd_b, upd_c;
  logic        rdy_a, rdy_b, rdy_c;

  logic [31:0] prev_a, prev_b, prev_c;
  int vec = 0;
  int mis = 0;

  always #5 clk = ~clk;

  seg_disp_ctrl dut (
    .clk(clk), .rstn(rstn), .i_bin(i_bin),
    .i_bin_valid(i_bin_valid), .o_bin_ready(rdy_a),
    .i_dp_pos(i_dp_pos), .i_hold(i_hold),
    .o_data(data_a), .o_sw_state(sw_a), .o_ovf(ovf_a),
    .o_busy(busy_a), .o_upd(upd_a)
  );

  seg_disp_ctrl #(.P_OVF_SAT(1'b0)) dut_wrap (
    .clk(clk), .rstn(rstn), .i_bin(i_bin),
    .i_bin_valid(i_bin_valid), .o_bin_ready(rdy_b),
    .i_dp_pos(i_dp_pos), .i_hold(i_hold),
    .o_data(data_b), .o_sw_state(sw_b), .o_ovf(ovf_b),
    .o_busy(busy_b), .o_upd(upd_b)
  );

  seg_disp_ctrl #(.P_BLANK_EN(1'b0)) dut_nobl (
    .clk(clk), .rstn(rstn), .i_bin(i_bin),
    .i_bin_valid(i_bin_valid), .o_bin_ready(rdy_c),
    .i_dp_pos(i_dp_pos), .i_hold(i_hold),
    .o_data(data_c), .o_sw_state(sw_c), .o_ovf(ovf_c),
    .o_busy(busy_c), .o_upd(upd_c)
  );

  function automatic logic [31:0] model(input logic [31:0] v,
                                        input logic [2:0] dp,
                                        input bit sat,
                                        input bit blk);
    longint unsigned x;
    longint unsigned p;
    logic [31:0] r;
    bit ovf;
    x = v;
    p = 1;
    r = '0;
    ovf = (x > 64'd99_999_999);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] d;
      if (ovf && sat) d = 4'd9;
      else d = 4'((x / p) % 10);
      if (blk && !ovf && k != 0 && k > int'(dp) && x < p) d = 4'hA;
      r[k*4 +: 4] = d;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic start(input logic [31:0] v, input logic [2:0] dp);
    vec++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin
      mis++;
      $display("FAIL ready_before_accept: got %b%b%b want 111",
               rdy_a, rdy_b, rdy_c);
    end
    i_bin = v;
    i_dp_pos = dp;
    i_bin_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  // called #1 after the handshake edge; inputs are scrambled each cycle
  task automatic wait_done(input logic [31:0] v, input logic [2:0] dp,
                           input bit keep_valid);
    int n;
    logic [31:0] ea, eb, ec;
    logic eo;
    n = 0;
    i_bin_valid = keep_valid;
    while (n < 40) begin
      if (upd_a === 1'b1) break;
      vec++;
      if (busy_a !== 1'b1 || rdy_a !== 1'b0 || data_a !== prev_a
          || data_b !== prev_b || data_c !== prev_c) begin
        mis++;
        $display("FAIL in_flight n=%0d: busy=%b rdy=%b data=%h want 1 0 %h",
                 n, busy_a, rdy_a, data_a, prev_a);
      end
      i_bin = $urandom;
      i_dp_pos = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      n++;
    end
    vec++;
    if (n != 34 || upd_b !== 1'b1 || upd_c !== 1'b1) begin
      mis++;
      $display("FAIL latency v=%0d: got %0d edges want 34", v, n);
    end
    ea = model(v, dp, 1'b1, 1'b1);
    eb = model(v, dp, 1'b0, 1'b1);
    ec = model(v, dp, 1'b1, 1'b0);
    eo = (v > 32'd99_999_999);
    vec++;
    if (data_a !== ea) begin
      mis++;
      $display("FAIL data_sat v=%0d dp=%0d: got %h want %h", v, dp, data_a, ea);
    end
    vec++;
    if (data_b !== eb) begin
      mis++;
      $display("FAIL data_wrap v=%0d dp=%0d: got %h want %h", v, dp, data_b, eb);
    end
    vec++;
    if (data_c !== ec) begin
      mis++;
      $display("FAIL data_noblank v=%0d dp=%0d: got %h want %h", v, dp, data_c, ec);
    end
    vec++;
    if (sw_a !== dp || sw_b !== dp || sw_c !== dp) begin
      mis++;
      $display("FAIL sw_state: got %0d want %0d", sw_a, dp);
    end
    vec++;
    if (ovf_a !== eo || ovf_b !== eo || ovf_c !== eo) begin
      mis++;
      $display("FAIL ovf v=%0d: got %b%b%b want %b", v, ovf_a, ovf_b, ovf_c, eo);
    end
    vec++;
    if (busy_a !== 1'b0 || rdy_a !== !i_hold) begin
      mis++;
      $display("FAIL idle_after: busy=%b rdy=%b want 0 %b", busy_a, rdy_a, !i_hold);
    end
    prev_a = ea;
    prev_b = eb;
    prev_c = ec;
    if (!keep_valid) begin
      @(posedge clk); #1;
      vec++;
      if (upd_a !== 1'b0 || data_a !== prev_a || busy_a !== 1'b0) begin
        mis++;
        $display("FAIL upd_width: upd=%b busy=%b data=%h want 0 0 %h",
                 upd_a, busy_a, data_a, prev_a);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    vec++;
    if (data_a !== 32'hAAAA_AAAA || data_b !== 32'hAAAA_AAAA
        || data_c !== 32'hAAAA_AAAA || sw_a !== 3'd0 || ovf_a !== 1'b0
        || busy_a !== 1'b0 || upd_a !== 1'b0) begin
      mis++;
      $display("FAIL %s: data=%h sw=%0d ovf=%b busy=%b upd=%b want aaaaaaaa 0 0 0 0",
               tag, data_a, sw_a, ovf_a, busy_a, upd_a);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_values");
    rstn = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_release");
    vec++;
    if (rdy_a !== 1'b1) begin
      mis++;
      $display("FAIL ready_after_reset: got %b want 1", rdy_a);
    end
    prev_a = 32'hAAAA_AAAA;
    prev_b = 32'hAAAA_AAAA;
    prev_c = 32'hAAAA_AAAA;
  endtask

  task automatic test_directed();
    logic [31:0] vs [8] = '{32'd0, 32'd12_345_678, 32'd50, 32'd100_000_000,
                            32'd99_999_999, 32'hFFFF_FFFF, 32'd7, 32'd1_000};
    logic [2:0]  ds [8] = '{3'd0, 3'd2, 3'd3, 3'd0, 3'd7, 3'd1, 3'd6, 3'd0};
    for (int i = 0; i < 8; i++) begin
      start(vs[i], ds[i]);
      wait_done(vs[i], ds[i], 1'b0);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [2:0]  d;
    for (int i = 0; i < 24; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      d = 3'($urandom_range(0, 7));
      start(v, d);
      wait_done(v, d, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [2:0]  d;
    v = 32'd4_096;
    d = 3'd1;
    start(v, d);
    wait_done(v, d, 1'b1);
    v = i_bin;
    d = i_dp_pos;
    @(posedge clk); #1;
    vec++;
    if (busy_a !== 1'b1 || upd_a !== 1'b0) begin
      mis++;
      $display("FAIL b2b_accept: busy=%b upd=%b want 1 0", busy_a, upd_a);
    end
    wait_done(v, d, 1'b0);
  endtask

  task automatic test_hold();
    logic [31:0] v;
    v = 32'd31_415;
    start(v, 3'd4);
    i_hold = 1'b1;
    wait_done(v, 3'd4, 1'b0);
    i_bin_valid = 1'b1;
    i_bin = 32'd42;
    repeat (6) begin
      @(posedge clk); #1;
      vec++;
      if (rdy_a !== 1'b0 || busy_a !== 1'b0 || upd_a !== 1'b0
          || data_a !== prev_a) begin
        mis++;
        $display("FAIL hold_block: rdy=%b busy=%b data=%h want 0 0 %h",
                 rdy_a, busy_a, data_a, prev_a);
      end
    end
    i_bin_valid = 1'b0;
    i_hold = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    start(32'd87_654_321, 3'd5);
    i_bin_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    check_reset_vals("async_reset_mid");
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    vec++;
    if (rdy_a !== 1'b1) begin
      mis++;
      $display("FAIL ready_after_mid_reset: got %b want 1", rdy_a);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (upd_a !== 1'b0 || data_a !== 32'hAAAA_AAAA) seen = 1'b1;
    end
    vec++;
    if (seen) begin
      mis++;
      $display("FAIL discard_after_reset: got upd/data change want none");
    end
    prev_a = 32'hAAAA_AAAA;
    prev_b = 32'hAAAA_AAAA;
    prev_c = 32'hAAAA_AAAA;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_directed();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
SEG_DISP_CTRL -- requirements
Module: seg_disp_ctrl

Interface
REQ-001 The block SHALL have parameter P_OVF_SAT, default 1: 1 = saturate the display on overflow; 0 = show the low 8 decimal digits.
REQ-002 The block SHALL have parameter P_BLANK_EN, default 1: 1 = leading-zero blanking enabled.
REQ-003 The block SHALL have clk  input  1  system clock; all logic is on the rising edge.
REQ-004 The block SHALL have rstn  input  1  reset: asynchronous, active-low.
REQ-005 The block SHALL have i_bin  input  32  unsigned binary value to display.
REQ-006 The block SHALL have i_bin_valid  input  1  i_bin and i_dp_pos are valid.
REQ-007 The block SHALL have o_bin_ready  output  1  block accepts a value this cycle.
REQ-008 The block SHALL have i_dp_pos  input  3  digit index (0 = rightmost) carrying the decimal point.
REQ-009 The block SHALL have i_hold  input  1  freeze display: no new values are accepted.
REQ-010 The block SHALL have o_data  output  32  8 BCD nibbles for the display driver; nibble 4'hA = blank digit.
REQ-011 The block SHALL have o_sw_state  output  3  decimal-point digit index for the display driver.
REQ-012 The block SHALL have o_ovf  output  1  last displayed value exceeded 99_999_999.
REQ-013 The block SHALL have o_busy  output  1  a conversion is in progress.
REQ-014 The block SHALL have o_upd  output  1  one-cycle pulse when o_data/o_sw_state/o_ovf update.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, BLANK and UPDATE.
REQ-016 o_bin_ready SHALL = (state==IDLE) && !i_hold, combinationally.
REQ-017 A handshake SHALL occur on an edge where i_bin_valid && o_bin_ready.
  - i_bin is captured into a 32-bit shift register.
  - i_dp_pos is captured into an internal register.
  - The 40-bit BCD accumulator and the 5-bit iteration counter are cleared.
  - The state moves to SHIFT.
REQ-018 SHIFT SHALL perform one double-dabble iteration per cycle.
  - Each of the 10 BCD nibbles >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - After exactly 32 iterations the state moves to BLANK.
REQ-019 BLANK SHALL take one cycle and evaluate, from the 40-bit BCD result:
  - overflow = upper two nibbles nonzero.
  - blanking mask for the low 8 digits.
  - Then the state moves to UPDATE.
REQ-020 Overflow handling SHALL follow P_OVF_SAT:
  - P_OVF_SAT=1: the displayed digits become 9999_9999 (BCD).
  - P_OVF_SAT=0: the displayed digits are the low 8 nibbles.
  - Either way, o_ovf is set.
REQ-021 Leading-zero blanking (P_BLANK_EN=1) SHALL set digit k to 4'hA if all of the following hold:
  - digit k and every digit above it are 0;
  - k > captured dp position;
  - k != 0;
  - there is no overflow.
  - Otherwise the digit keeps its BCD value.
REQ-022 With P_BLANK_EN=0 no digit SHALL be blanked.
REQ-023 UPDATE SHALL:
  - register o_data, o_sw_state (= captured dp position) and o_ovf;
  - assert o_upd for exactly that one cycle;
  - return to IDLE.
REQ-024 Latency SHALL be fixed:
  - Handshake at edge T; SHIFT on edges T+1..T+32; BLANK on T+33; UPDATE on T+34.
  - o_data is new from edge T+34, and o_upd is high during cycle T+34..T+35.
REQ-025 o_busy SHALL be 1 in SHIFT, BLANK and UPDATE, and 0 in IDLE.
REQ-026 i_bin_valid while not ready SHALL be ignored; the value is not queued. The upstream holds or drops it.
REQ-027 i_hold asserted mid-conversion SHALL NOT abort it; the conversion completes and updates the outputs. Further accepts are blocked while i_hold=1.
REQ-028 o_data, o_sw_state and o_ovf SHALL be stable between o_upd pulses.
REQ-029 Changes on i_bin and i_dp_pos after the handshake SHALL have no effect on the conversion in progress.
REQ-030 Back-to-back operation SHALL allow a handshake on the cycle after UPDATE (IDLE), giving a maximum rate of 1 value per 35 cycles.

Reset
REQ-031 On rstn low, the state SHALL go to IDLE immediately (asynchronously).
REQ-032 Reset values SHALL be:
  - o_data = 32'hAAAA_AAAA (all blank);
  - o_sw_state = 0, o_ovf = 0, o_busy = 0, o_upd = 0;
  - iteration counter = 0 and all internal registers = 0.
REQ-033 A reset during a conversion SHALL discard it, with no o_upd pulse afterwards.
REQ-034 After rstn deasserts, o_bin_ready SHALL be 1 on the first clock if i_hold=0.

Verification
REQ-035 Scenario: i_bin=0, dp=0 -> o_data=32'hAAAA_AAA0, o_ovf=0, o_upd one cycle at T+34.
REQ-036 Scenario: i_bin=12_345_678, dp=2 -> o_data=32'h1234_5678, o_sw_state=2, latency exactly 34 edges.
REQ-037 Scenario: i_bin=50, dp=3 -> o_data=32'hAAAA_0050, o_sw_state=3.
REQ-038 Scenario: i_bin=100_000_000 -> o_ovf=1, o_data=32'h9999_9999 (P_OVF_SAT=1); with P_OVF_SAT=0 -> o_data=32'h0000_0000.
REQ-039 Scenario: i_bin_valid held with alternating values across a conversion -> o_bin_ready=0 on T+1..T+34; only the first value is displayed; the next accept is at T+35.
REQ-040 Scenario: rstn pulsed low at the 10th SHIFT cycle -> outputs return to reset values, no o_upd pulse, o_bin_ready=1 after release. i_hold=1 -> o_bin_ready stays 0 and o_data is unchanged.
